// File: rtl/up_down_step_driver.sv
// Step/direction driver that walks a position mirror toward a requested target.
// Optional abort support is enabled by defining UP_DOWN_STEP_DRIVER_ABORT_EN.
module up_down_step_driver #(
    parameter int unsigned INPUT_BIT_WIDTH = 8,
    parameter int unsigned STEP_PERIOD     = 4,
    parameter int unsigned SETUP_CYCLES    = 1
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [INPUT_BIT_WIDTH-1:0] Target,
    input  logic                       TargetValid,
    output logic                       TargetReady,
    output logic                       UpDownMode,
    output logic                       Step,
    output logic [INPUT_BIT_WIDTH-1:0] Position,
    output logic                       Busy,
    output logic                       Done
`ifdef UP_DOWN_STEP_DRIVER_ABORT_EN
    ,
    input  logic                       Abort,
    output logic                       Aborted
`endif
);

    localparam int unsigned CNT_MAX   = (SETUP_CYCLES > STEP_PERIOD) ? SETUP_CYCLES : STEP_PERIOD;
    localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned SETUP_LD  = (SETUP_CYCLES >= 1) ? SETUP_CYCLES - 1 : 0;
    localparam int unsigned WAIT_LD   = (STEP_PERIOD >= 2) ? STEP_PERIOD - 2 : 0;
    localparam bit          BACK2BACK = (STEP_PERIOD <= 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STEP,
        S_WAIT,
        S_DONE
    } state_e;

    state_e                       state_q;
    logic [INPUT_BIT_WIDTH-1:0]   pos_q;
    logic [INPUT_BIT_WIDTH-1:0]   target_q;
    logic [CNT_W-1:0]             cnt_q;
    logic                         updown_q;
    logic                         step_q;
    logic                         busy_q;
    logic                         done_q;
    logic                         ready_q;
    logic                         abort_req;
    logic [INPUT_BIT_WIDTH-1:0]   pos_next;

`ifdef UP_DOWN_STEP_DRIVER_ABORT_EN
    logic                         aborted_q;
    assign abort_req = Abort;
    assign Aborted   = aborted_q;
`else
    assign abort_req = 1'b0;
`endif

    // Position after the strobe currently on the wire; never wraps because moves are monotonic.
    assign pos_next = updown_q ? (pos_q + INPUT_BIT_WIDTH'(1)) : (pos_q - INPUT_BIT_WIDTH'(1));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            pos_q     <= '0;
            target_q  <= '0;
            cnt_q     <= '0;
            updown_q  <= 1'b1;
            step_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
`ifdef UP_DOWN_STEP_DRIVER_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            step_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UP_DOWN_STEP_DRIVER_ABORT_EN
            aborted_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (TargetValid) begin
                        target_q <= Target;
                        ready_q  <= 1'b0;
                        if (Target == pos_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= S_SETUP;
                            updown_q <= (Target > pos_q);
                            busy_q   <= 1'b1;
                            cnt_q    <= CNT_W'(SETUP_LD);
                        end
                    end
                end

                S_SETUP: begin
                    if (abort_req) begin
                        state_q   <= S_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
`ifdef UP_DOWN_STEP_DRIVER_ABORT_EN
                        aborted_q <= 1'b1;
`endif
                    end else if (cnt_q == CNT_W'(0)) begin
                        state_q <= S_STEP;
                        step_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                // The strobe is on the wire this cycle; the mirror follows it on this edge.
                S_STEP: begin
                    pos_q <= pos_next;
                    if (pos_next == target_q) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (abort_req) begin
                        state_q   <= S_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
`ifdef UP_DOWN_STEP_DRIVER_ABORT_EN
                        aborted_q <= 1'b1;
`endif
                    end else if (BACK2BACK) begin
                        state_q <= S_STEP;
                        step_q  <= 1'b1;
                    end else begin
                        state_q <= S_WAIT;
                        cnt_q   <= CNT_W'(WAIT_LD);
                    end
                end

                S_WAIT: begin
                    if (abort_req) begin
                        state_q   <= S_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
`ifdef UP_DOWN_STEP_DRIVER_ABORT_EN
                        aborted_q <= 1'b1;
`endif
                    end else if (cnt_q == CNT_W'(0)) begin
                        state_q <= S_STEP;
                        step_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign TargetReady = ready_q;
    assign UpDownMode  = updown_q;
    assign Step        = step_q;
    assign Position    = pos_q;
    assign Busy        = busy_q;
    assign Done        = done_q;

endmodule

// File: tb/tb_up_down_step_driver.sv
// Randomized cycle-accurate bench for up_down_step_driver against a schedule-based model.
module tb_up_down_step_driver;

    localparam int W = 8;
    localparam int P = 4;
    localparam int S = 1;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic [W-1:0] Target = '0;
    logic         TargetValid = 1'b0;
    logic         TargetReady;
    logic         UpDownMode;
    logic         Step;
    logic [W-1:0] Position;
    logic         Busy;
    logic         Done;
`ifdef UP_DOWN_STEP_DRIVER_ABORT_EN
    logic         Abort = 1'b0;
    logic         Aborted;
`endif

    int errors = 0;
    int checks = 0;
    int model_pos = 0;
    bit model_dir = 1'b1;

    up_down_step_driver #(
        .INPUT_BIT_WIDTH(W),
        .STEP_PERIOD    (P),
        .SETUP_CYCLES   (S)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Target     (Target),
        .TargetValid(TargetValid),
        .TargetReady(TargetReady),
        .UpDownMode (UpDownMode),
        .Step       (Step),
        .Position   (Position),
        .Busy       (Busy),
        .Done       (Done)
`ifdef UP_DOWN_STEP_DRIVER_ABORT_EN
        ,
        .Abort      (Abort),
        .Aborted    (Aborted)
`endif
    );

    always #5 Clk = ~Clk;

    // Steps completed before cycle j of a move of n steps (cycle 1 = first cycle after accept).
    function automatic int steps_before(input int j, input int n);
        int s;
        if (n == 0 || j <= S + 1) return 0;
        s = (j - S - 2) / P + 1;
        return (s > n) ? n : s;
    endfunction

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({Step, Busy, Done, TargetReady, UpDownMode, Position} !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0})
            $display("FAIL %s: step=%b busy=%b done=%b ready=%b mode=%b pos=%0d, required 0 0 0 1 1 0",
                     name, Step, Busy, Done, TargetReady, UpDownMode, Position);
`ifdef UP_DOWN_STEP_DRIVER_ABORT_EN
        checks++;
        if (Aborted !== 1'b0) $display("FAIL %s aborted: got %b required 0", name, Aborted);
`endif
    endtask

    // Issue one command and check every output on every cycle until back in IDLE.
    task automatic do_move(input int tgt, input bit noise, input string name);
        int n, jdone, sb, p0;
        bit dir, exp_step;
        logic [12:0] got, exp;
        p0    = model_pos;
        n     = (tgt > p0) ? tgt - p0 : p0 - tgt;
        dir   = (n == 0) ? model_dir : (tgt > p0);
        jdone = (n == 0) ? 1 : S + 1 + (n - 1) * P + 1;
        @(negedge Clk);
        checks++;
        if (TargetReady !== 1'b1) begin
            errors++;
            $display("FAIL %s ready-before-accept: got %b required 1", name, TargetReady);
        end
        Target      = W'(tgt);
        TargetValid = 1'b1;
        @(posedge Clk);
        for (int j = 1; j <= jdone + 1; j++) begin
            #1;
            TargetValid = noise && (j <= jdone) ? 1'($urandom) : 1'b0;
            Target      = noise ? W'($urandom) : W'(tgt);
            @(negedge Clk);
            sb       = steps_before(j, n);
            exp_step = (n > 0) && (j >= S + 1) && ((j - S - 1) % P == 0) && ((j - S - 1) / P < n);
            exp = {exp_step, (n > 0) && (j < jdone), j == jdone, j == jdone + 1, dir,
                   W'(dir ? p0 + sb : p0 - sb)};
            got = {Step, Busy, Done, TargetReady, UpDownMode, Position};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d {step,busy,done,ready,mode,pos}: got %b_%0d required %b_%0d",
                         name, j, got[12:8], got[7:0], exp[12:8], exp[7:0]);
            end
`ifdef UP_DOWN_STEP_DRIVER_ABORT_EN
            checks++;
            if (Aborted !== 1'b0) begin
                errors++;
                $display("FAIL %s cycle %0d aborted: got %b required 0", name, j, Aborted);
            end
`endif
            if (j <= jdone) @(posedge Clk);
        end
        TargetValid = 1'b0;
        model_pos = tgt;
        model_dir = dir;
    endtask

    task automatic test_reset;
        #2 Reset = 1'b0;
        #2 check_reset_outputs("reset_async");
        if ({Step, Busy, Done, TargetReady, UpDownMode, Position} !== 13'b0_0_0_1_1_00000000) errors++;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check_reset_outputs("reset_held");
        if ({Step, Busy, Done, TargetReady, UpDownMode, Position} !== 13'b0_0_0_1_1_00000000) errors++;
        Reset = 1'b1;
        model_pos = 0;
        model_dir = 1'b1;
    endtask

    task automatic test_up_move;
        do_move(5, 1'b0, "up_0_to_5");
    endtask

    task automatic test_down_move;
        do_move(2, 1'b0, "down_5_to_2");
    endtask

    task automatic test_same_target;
        do_move(2, 1'b0, "same_2");
    endtask

    task automatic test_full_range;
        do_move(255, 1'b1, "up_to_255");
        do_move(0, 1'b1, "down_to_0");
    endtask

    // Reset mid-move at position 40 during 0 -> 100, then a clean move to 3.
    task automatic test_reset_mid_move;
        if (model_pos != 0) do_move(0, 1'b0, "prep_0");
        @(negedge Clk);
        Target      = 8'd100;
        TargetValid = 1'b1;
        @(posedge Clk);
        #1 TargetValid = 1'b0;
        Target = 8'd7;
        repeat (S + 1 + 39 * P) @(posedge Clk);
        #1;
        checks++;
        if (Position !== 8'd40 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL midmove_pos: got pos=%0d busy=%b required pos=40 busy=1", Position, Busy);
        end
        #1 Reset = 1'b0;
        #1 check_reset_outputs("reset_mid_move");
        if ({Step, Busy, Done, TargetReady, UpDownMode, Position} !== 13'b0_0_0_1_1_00000000) errors++;
        @(negedge Clk);
        Reset = 1'b1;
        model_pos = 0;
        model_dir = 1'b1;
        do_move(3, 1'b0, "after_reset_to_3");
    endtask

    task automatic test_random;
        for (int i = 0; i < 10; i++) begin
            int t;
            t = (i % 3 == 0) ? model_pos : int'($urandom_range(0, 255));
            repeat ($urandom_range(0, 3)) @(posedge Clk);
            do_move(t, 1'b1, "random");
        end
    endtask

`ifdef UP_DOWN_STEP_DRIVER_ABORT_EN
    // Abort in the WAIT following the 10th step of 0 -> 50, then abort while idle.
    task automatic test_abort;
        bit exp_step;
        logic [13:0] got, exp;
        if (model_pos != 0) do_move(0, 1'b0, "prep_abort");
        @(negedge Clk);
        Target      = 8'd50;
        TargetValid = 1'b1;
        @(posedge Clk);
        for (int j = 1; j <= 41; j++) begin
            #1;
            TargetValid = 1'b0;
            Abort       = (j == 39);
            @(negedge Clk);
            exp_step = (j >= 2) && (j <= 38) && ((j - 2) % 4 == 0);
            exp = {exp_step, j < 40, j == 40, j == 40, j == 41, 1'b1, W'(steps_before(j, 10))};
            got = {Step, Busy, Done, Aborted, TargetReady, UpDownMode, Position};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL abort cycle %0d {step,busy,done,aborted,ready,mode,pos}: got %b_%0d required %b_%0d",
                         j, got[13:8], got[7:0], exp[13:8], exp[7:0]);
            end
            if (j < 41) @(posedge Clk);
        end
        Abort = 1'b0;
        model_pos = 10;
        model_dir = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(posedge Clk);
            #1 Abort = 1'b1;
            @(negedge Clk);
            checks++;
            if ({Step, Busy, Done, Aborted, TargetReady, Position} !== {5'b00001, 8'd10}) begin
                errors++;
                $display("FAIL abort_idle: step=%b busy=%b done=%b aborted=%b ready=%b pos=%0d required 0 0 0 0 1 10",
                         Step, Busy, Done, Aborted, TargetReady, Position);
            end
        end
        Abort = 1'b0;
        do_move(12, 1'b0, "after_abort");
    endtask
`endif

    initial begin
        test_reset;
        test_up_move;
        test_down_move;
        test_same_target;
        test_full_range;
        test_reset_mid_move;
        test_random;
`ifdef UP_DOWN_STEP_DRIVER_ABORT_EN
        test_abort;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/up_down_step_driver.md
Name: up_down_step_driver

Overview:
Command-side driver for the up/down counter interface. Accepts a target count over a valid/ready handshake and emits direction (UpDownMode) plus single-cycle Step strobes until its internal position mirror equals the target. Position tracks, step for step, what a downstream saturating up/down counter holds. Sits between control logic and counter-style actuators and position registers.

Parameters:
INPUT_BIT_WIDTH, 8, width of Target and Position.
STEP_PERIOD, 4, clock cycles between consecutive Step strobes; must be >= 1.
SETUP_CYCLES, 1, cycles UpDownMode is held stable before the first Step of a move; must be >= 1.

Ports:
Clk  input  1  system clock; all state updates on the rising edge.
Reset  input  1  asynchronous, active-low reset.
Target  input  INPUT_BIT_WIDTH  requested position.
TargetValid  input  1  Target is valid.
TargetReady  output  1  driver can accept a command (IDLE only).
UpDownMode  output  1  direction: 1 = up, 0 = down; stable throughout a move.
Step  output  1  one-cycle count strobe.
Position  output  INPUT_BIT_WIDTH  current position mirror.
Busy  output  1  move in progress (SETUP, STEP, WAIT).
Done  output  1  one-cycle pulse when a command completes.

Behaviour:
- Reset low (async): state IDLE, Position=0, UpDownMode=1, Step=0, Busy=0, Done=0, TargetReady=1. Release is synchronous to Clk.
- States: IDLE, SETUP, STEP, WAIT, DONE. All outputs are registered.
- IDLE: TargetReady=1. On the edge where TargetValid&&TargetReady, latch Target.
  - If Target==Position, go to DONE. No Step, UpDownMode unchanged.
  - Otherwise set UpDownMode=(Target>Position) and go to SETUP. Busy=1, TargetReady=0 from the next cycle.
- SETUP: lasts exactly SETUP_CYCLES cycles, then STEP.
- STEP: Step=1 for exactly one cycle. Position increments (UpDownMode=1) or decrements (UpDownMode=0) on that same edge.
  - If the new Position equals the latched target, go to DONE.
  - Otherwise go to WAIT, or straight back to STEP when STEP_PERIOD=1.
- WAIT: lasts STEP_PERIOD-1 cycles, then STEP. Consecutive Step strobes are exactly STEP_PERIOD cycles apart.
- DONE: Done=1 for one cycle, Busy=0, then IDLE.
- Latency: accept at edge k → UpDownMode valid from k+1 → first Step in cycle k+1+SETUP_CYCLES.
  - Number of steps = |Target-Position|.
  - Done is asserted the cycle after the last Step.
- Moves are monotonic toward the target, so Position never wraps. 0 and 2^W-1 are legal endpoints.
- TargetValid while Busy: ignored, no effect, TargetReady=0. Target may change freely when not accepted.
- UpDownMode never changes while Busy=1.
- Reset mid-move: immediate return to reset values; the latched target is discarded.

Optional Feature:
Macro UP_DOWN_STEP_DRIVER_ABORT_EN.
- Defined:
  - Adds input port Abort (1 bit) and output port Aborted (1 bit, reset 0).
  - Abort high while Busy: a move in SETUP or WAIT goes to DONE on the next edge; a Step in progress completes first.
  - Aborted=1 alongside Done, for the same single cycle.
  - Position keeps its reached value.
  - Abort in IDLE has no effect.
- Undefined: neither port exists; every accepted move runs to the target.

Test Plan:
All scenarios use W=8, STEP_PERIOD=4, SETUP_CYCLES=1.
1. Reset, then Target=5 accepted → UpDownMode=1; 5 Step pulses 4 cycles apart, first pulse 2 cycles after accept; Position=5; one Done pulse; TargetReady low until Done.
2. From 5, Target=2 → UpDownMode=0 one cycle before the first Step; 3 pulses; Position=2; Done once.
3. From 2, Target=2 → no Step; Done 1 cycle after accept; Busy stays 0.
4. From 2, Target=255 → 253 pulses, Position=255, no wrap. Then Target=0 → 255 down pulses, Position=0. Target=7 presented mid-move is not accepted.
5. Reset low at Position=40 during a move to 100 → same cycle: Step=0, Busy=0, Position=0, TargetReady=1. After release, Target=3 → 3 pulses, Position=3.
6. With macro: from 0, Target=50; Abort pulsed in WAIT after the 10th Step → no further Step; Done and Aborted together; Position=10. Abort in IDLE → no response.
